wb_forward_unit: RTL and testbench

WB_FORWARD_UNIT -- requirements
Module: wb_forward_unit

---
 rtl/wb_forward_unit.sv | 110 +++++++++++
 tb/tb_wb_forward_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_forward_unit.sv
// Two-stage (M, W) writeback pipeline with ID-operand forwarding and hazard stall.
// FWD_EN=1 bypasses from M/W and stalls only on load-use; FWD_EN=0 stalls on any M/W hazard.
module wb_forward_unit #(
    parameter int FWD_EN = 1,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [2:0]        ex_dest,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_is_load,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [2:0]        id_src1,
    input  logic [2:0]        id_src2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic [2:0]        rf_srcreg1,
    output logic [2:0]        rf_srcreg2,
    output logic              rf_write,
    output logic [2:0]        rf_destreg,
    output logic [DATA_W-1:0] rf_wrtData,
    output logic [DATA_W-1:0] opnd1,
    output logic [DATA_W-1:0] opnd2,
    output logic              stall
);

    logic              vld_p1;
    logic              is_load_p1;
    logic [2:0]        dest_p1;
    logic [DATA_W-1:0] result_p1;

    logic              vld_p2;
    logic [2:0]        dest_p2;
    logic [DATA_W-1:0] data_p2;

    logic m_hit1, m_hit2, w_hit1, w_hit2;

    // A load's M-stage result is not known yet, so it is never a bypass source.
    function automatic logic [DATA_W-1:0] resolve_opnd(
        input logic              m_hit,
        input logic              m_load,
        input logic              w_hit,
        input logic [DATA_W-1:0] m_val,
        input logic [DATA_W-1:0] w_val,
        input logic [DATA_W-1:0] rf_val
    );
        if (m_hit && !m_load)
            return m_val;
        else if (w_hit)
            return w_val;
        else
            return rf_val;
    endfunction

    // EX -> M stage boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            is_load_p1 <= 1'b0;
            dest_p1    <= '0;
            result_p1  <= '0;
        end else begin
            vld_p1     <= ex_valid;
            is_load_p1 <= ex_valid & ex_is_load;
            dest_p1    <= ex_dest;
            result_p1  <= ex_result;
        end
    end

    // M -> W stage boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2  <= 1'b0;
            dest_p2 <= '0;
            data_p2 <= '0;
        end else begin
            vld_p2  <= vld_p1;
            dest_p2 <= dest_p1;
            data_p2 <= is_load_p1 ? mem_rdata : result_p1;
        end
    end

    assign rf_write   = vld_p2;
    assign rf_destreg = dest_p2;
    assign rf_wrtData = data_p2;

    assign rf_srcreg1 = id_src1;
    assign rf_srcreg2 = id_src2;

    assign m_hit1 = id_use1 & vld_p1 & (dest_p1 == id_src1);
    assign m_hit2 = id_use2 & vld_p1 & (dest_p1 == id_src2);
    assign w_hit1 = id_use1 & vld_p2 & (dest_p2 == id_src1);
    assign w_hit2 = id_use2 & vld_p2 & (dest_p2 == id_src2);

    generate
        if (FWD_EN != 0) begin : g_fwd
            assign opnd1 = resolve_opnd(m_hit1, is_load_p1, w_hit1, result_p1, data_p2, rf_rdata1);
            assign opnd2 = resolve_opnd(m_hit2, is_load_p1, w_hit2, result_p1, data_p2, rf_rdata2);
            assign stall = (m_hit1 | m_hit2) & is_load_p1;
        end else begin : g_nofwd
            assign opnd1 = rf_rdata1;
            assign opnd2 = rf_rdata2;
            assign stall = m_hit1 | m_hit2 | w_hit1 | w_hit2;
        end
    endgenerate

endmodule

// File: tb/tb_wb_forward_unit.sv
// Directed-vector bench for wb_forward_unit: a forwarding instance (a_*) and a stall-only instance (b_*)
// share stimulus; each keeps its own register-file model.
module tb_wb_forward_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, rf_load;
    logic       ex_valid, ex_is_load, id_use1, id_use2;
    logic [2:0] ex_dest, id_src1, id_src2;
    logic [7:0] ex_result, mem_rdata;

    logic [7:0] a_rf_rdata1, a_rf_rdata2, b_rf_rdata1, b_rf_rdata2;
    logic [2:0] a_rf_srcreg1, a_rf_srcreg2, b_rf_srcreg1, b_rf_srcreg2;
    logic       a_rf_write, b_rf_write, a_stall, b_stall;
    logic [2:0] a_rf_destreg, b_rf_destreg;
    logic [7:0] a_rf_wrtData, b_rf_wrtData, a_opnd1, a_opnd2, b_opnd1, b_opnd2;

    wb_forward_unit #(.FWD_EN(1)) dut_a (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_dest(ex_dest), .ex_result(ex_result), .ex_is_load(ex_is_load),
        .mem_rdata(mem_rdata),
        .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1), .id_use2(id_use2),
        .rf_rdata1(a_rf_rdata1), .rf_rdata2(a_rf_rdata2),
        .rf_srcreg1(a_rf_srcreg1), .rf_srcreg2(a_rf_srcreg2),
        .rf_write(a_rf_write), .rf_destreg(a_rf_destreg), .rf_wrtData(a_rf_wrtData),
        .opnd1(a_opnd1), .opnd2(a_opnd2), .stall(a_stall)
    );

    wb_forward_unit #(.FWD_EN(0)) dut_b (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_dest(ex_dest), .ex_result(ex_result), .ex_is_load(ex_is_load),
        .mem_rdata(mem_rdata),
        .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1), .id_use2(id_use2),
        .rf_rdata1(b_rf_rdata1), .rf_rdata2(b_rf_rdata2),
        .rf_srcreg1(b_rf_srcreg1), .rf_srcreg2(b_rf_srcreg2),
        .rf_write(b_rf_write), .rf_destreg(b_rf_destreg), .rf_wrtData(b_rf_wrtData),
        .opnd1(b_opnd1), .opnd2(b_opnd2), .stall(b_stall)
    );

    // Register-file models: preset to 0xA0+i, then written from each DUT's write port.
    logic [7:0] rf_a [8];
    logic [7:0] rf_b [8];
    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 8; i++) begin
                rf_a[i] <= 8'hA0 + 8'(i);
                rf_b[i] <= 8'hA0 + 8'(i);
            end
        end else begin
            if (a_rf_write) rf_a[a_rf_destreg] <= a_rf_wrtData;
            if (b_rf_write) rf_b[b_rf_destreg] <= b_rf_wrtData;
        end
    end
    assign a_rf_rdata1 = rf_a[a_rf_srcreg1];
    assign a_rf_rdata2 = rf_a[a_rf_srcreg2];
    assign b_rf_rdata1 = rf_b[b_rf_srcreg1];
    assign b_rf_rdata2 = rf_b[b_rf_srcreg2];

    localparam logic       DA = 1'b0, DB = 1'b1;
    localparam logic [2:0] F_STALL = 3'd0, F_OP1 = 3'd1, F_OP2 = 3'd2,
                           F_WR = 3'd3, F_DST = 3'd4, F_WDAT = 3'd5;

    typedef struct packed {
        logic       sel;
        logic [2:0] fld;
        logic [7:0] val;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic exp_push(input logic sel, input logic [2:0] fld, input logic [7:0] val, input string name);
        exp_t e;
        e.sel = sel;
        e.fld = fld;
        e.val = val;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    function automatic logic [7:0] actual(input logic sel, input logic [2:0] fld);
        case (fld)
            F_STALL: return sel ? {7'd0, b_stall} : {7'd0, a_stall};
            F_OP1:   return sel ? b_opnd1 : a_opnd1;
            F_OP2:   return sel ? b_opnd2 : a_opnd2;
            F_WR:    return sel ? {7'd0, b_rf_write} : {7'd0, a_rf_write};
            F_DST:   return sel ? {5'd0, b_rf_destreg} : {5'd0, a_rf_destreg};
            default: return sel ? b_rf_wrtData : a_rf_wrtData;
        endcase
    endfunction

    task automatic check_rf(input logic sel, input int idx, input logic [7:0] val, input string name);
        logic [7:0] act;
        act = sel ? rf_b[idx] : rf_a[idx];
        checks++;
        if (act !== val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, val);
        end
    endtask

    // Monitor: every expectation queued during a cycle is compared at that cycle's falling edge.
    always @(negedge clk) begin : monitor
        exp_t       e;
        string      nm;
        logic [7:0] act;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = actual(e.sel, e.fld);
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", nm, act, e.val);
            end
        end
    end

    task automatic cyc(input logic rs, input logic ev, input logic [2:0] ed, input logic [7:0] er,
                       input logic el, input logic [7:0] mr,
                       input logic u1, input logic [2:0] s1, input logic u2, input logic [2:0] s2);
        @(posedge clk);
        #1;
        reset      = rs;
        rf_load    = 1'b0;
        ex_valid   = ev;
        ex_dest    = ed;
        ex_result  = er;
        ex_is_load = el;
        mem_rdata  = mr;
        id_use1    = u1;
        id_src1    = s1;
        id_use2    = u2;
        id_src2    = s2;
    endtask

    initial begin
        reset = 1'b1; rf_load = 1'b1;
        ex_valid = 1'b0; ex_dest = '0; ex_result = '0; ex_is_load = 1'b0; mem_rdata = '0;
        id_use1 = 1'b0; id_src1 = '0; id_use2 = 1'b0; id_src2 = '0;
        repeat (2) @(posedge clk);

        // First cycle after reset
        cyc(0, 0,3'd0,8'h00,0,8'h00, 1,3'd5, 1,3'd6);
        exp_push(DA, F_WR,    8'h00, "rst_rf_write");
        exp_push(DA, F_DST,   8'h00, "rst_rf_destreg");
        exp_push(DA, F_WDAT,  8'h00, "rst_rf_wrtData");
        exp_push(DA, F_STALL, 8'h00, "rst_stall_a");
        exp_push(DB, F_STALL, 8'h00, "rst_stall_b");
        exp_push(DA, F_OP1,   8'hA5, "rst_opnd1");
        exp_push(DA, F_OP2,   8'hA6, "rst_opnd2");

        // Back-to-back ALU: r3 <= 0x5A
        cyc(0, 1,3'd3,8'h5A,0,8'h00, 0,3'd0, 0,3'd0);
        exp_push(DA, F_STALL, 8'h00, "alu_ex_stall");
        cyc(0, 0,3'd0,8'h00,0,8'h00, 1,3'd3, 0,3'd0);
        exp_push(DA, F_OP1,   8'h5A, "alu_fwd_m_opnd1");
        exp_push(DA, F_STALL, 8'h00, "alu_fwd_m_stall");
        exp_push(DB, F_STALL, 8'h01, "nofwd_m_stall");
        cyc(0, 0,3'd0,8'h00,0,8'h00, 1,3'd3, 0,3'd0);
        exp_push(DA, F_WR,    8'h01, "alu_rf_write");
        exp_push(DA, F_DST,   8'h03, "alu_rf_destreg");
        exp_push(DA, F_WDAT,  8'h5A, "alu_rf_wrtData");
        exp_push(DA, F_OP1,   8'h5A, "alu_fwd_w_opnd1");
        exp_push(DB, F_STALL, 8'h01, "nofwd_w_stall");
        exp_push(DB, F_OP1,   8'hA3, "nofwd_w_opnd1_rf");
        cyc(0, 0,3'd0,8'h00,0,8'h00, 1,3'd3, 0,3'd0);
        exp_push(DA, F_WR,    8'h00, "alu_after_rf_write");
        exp_push(DA, F_OP1,   8'h5A, "alu_rf_opnd1");
        exp_push(DB, F_STALL, 8'h00, "nofwd_clear_stall");
        exp_push(DB, F_OP1,   8'h5A, "nofwd_rf_opnd1");

        // Load-use: load r2, data 0xC3
        cyc(0, 1,3'd2,8'hEE,1,8'h00, 0,3'd0, 0,3'd0);
        cyc(0, 0,3'd0,8'h00,0,8'hC3, 0,3'd0, 1,3'd2);
        exp_push(DA, F_STALL, 8'h01, "ld_use_stall");
        cyc(0, 0,3'd0,8'h00,0,8'h00, 0,3'd0, 1,3'd2);
        exp_push(DA, F_STALL, 8'h00, "ld_use_release");
        exp_push(DA, F_OP2,   8'hC3, "ld_use_opnd2_w");
        exp_push(DA, F_WR,    8'h01, "ld_rf_write");
        exp_push(DA, F_DST,   8'h02, "ld_rf_destreg");
        exp_push(DA, F_WDAT,  8'hC3, "ld_rf_wrtData");

        // Unused src1 matching an M load: no stall
        cyc(0, 1,3'd7,8'h00,1,8'h00, 0,3'd0, 0,3'd0);
        cyc(0, 0,3'd0,8'h00,0,8'h99, 0,3'd7, 1,3'd1);
        exp_push(DA, F_STALL, 8'h00, "unused_src_stall");
        exp_push(DA, F_OP2,   8'hA1, "unused_src_opnd2");
        cyc(0, 0,3'd0,8'h00,0,8'h00, 0,3'd0, 0,3'd0);
        exp_push(DA, F_WDAT,  8'h99, "ld2_rf_wrtData");
        exp_push(DA, F_DST,   8'h07, "ld2_rf_destreg");

        // Double match: r1 <= 0x11 then r1 <= 0x22
        cyc(0, 1,3'd1,8'h11,0,8'h00, 0,3'd0, 0,3'd0);
        cyc(0, 1,3'd1,8'h22,0,8'h00, 0,3'd0, 0,3'd0);
        cyc(0, 0,3'd0,8'h00,0,8'h00, 1,3'd1, 1,3'd1);
        exp_push(DA, F_OP1,   8'h22, "dbl_m_beats_w_op1");
        exp_push(DA, F_OP2,   8'h22, "dbl_m_beats_w_op2");
        exp_push(DA, F_STALL, 8'h00, "dbl_stall");
        exp_push(DB, F_STALL, 8'h01, "dbl_nofwd_stall");
        exp_push(DB, F_OP1,   8'hA1, "dbl_nofwd_opnd1");
        cyc(0, 0,3'd0,8'h00,0,8'h00, 1,3'd1, 0,3'd0);
        exp_push(DA, F_OP1,   8'h22, "dbl_w_opnd1");
        exp_push(DB, F_STALL, 8'h01, "dbl_nofwd_stall2");
        exp_push(DB, F_OP1,   8'h11, "dbl_nofwd_opnd1_old");
        cyc(0, 0,3'd0,8'h00,0,8'h00, 1,3'd1, 0,3'd0);
        exp_push(DA, F_OP1,   8'h22, "dbl_rf_opnd1");
        exp_push(DB, F_STALL, 8'h00, "dbl_nofwd_release");
        exp_push(DB, F_OP1,   8'h22, "dbl_nofwd_opnd1_new");

        // Stall-only instance: r4 <= 0x7F
        cyc(0, 1,3'd4,8'h7F,0,8'h00, 0,3'd0, 0,3'd0);
        cyc(0, 0,3'd0,8'h00,0,8'h00, 1,3'd4, 0,3'd0);
        exp_push(DB, F_STALL, 8'h01, "nf_r4_stall1");
        exp_push(DA, F_OP1,   8'h7F, "fwd_r4_opnd1");
        exp_push(DA, F_STALL, 8'h00, "fwd_r4_stall");
        cyc(0, 0,3'd0,8'h00,0,8'h00, 1,3'd4, 0,3'd0);
        exp_push(DB, F_STALL, 8'h01, "nf_r4_stall2");
        cyc(0, 0,3'd0,8'h00,0,8'h00, 1,3'd4, 0,3'd0);
        exp_push(DB, F_STALL, 8'h00, "nf_r4_release");
        exp_push(DB, F_OP1,   8'h7F, "nf_r4_opnd1");

        // Register 0 forwards like any other register
        cyc(0, 1,3'd0,8'h3C,0,8'h00, 0,3'd0, 0,3'd0);
        cyc(0, 0,3'd0,8'h00,0,8'h00, 0,3'd0, 1,3'd0);
        exp_push(DA, F_OP2,   8'h3C, "r0_fwd_opnd2");

        // ex_valid=0 slot carries nothing
        cyc(0, 0,3'd5,8'hFF,1,8'h00, 0,3'd0, 0,3'd0);
        cyc(0, 0,3'd0,8'h00,0,8'h00, 1,3'd5, 0,3'd0);
        exp_push(DA, F_STALL, 8'h00, "inval_stall_a");
        exp_push(DB, F_STALL, 8'h00, "inval_stall_b");
        exp_push(DA, F_OP1,   8'hA5, "inval_opnd1");
        cyc(0, 0,3'd0,8'h00,0,8'h00, 1,3'd0, 0,3'd0);
        exp_push(DA, F_WR,    8'h00, "inval_rf_write");
        exp_push(DA, F_OP1,   8'h3C, "r0_rf_opnd1");

        // Reset while M (r5) and W (r6) are valid
        cyc(0, 1,3'd6,8'h66,0,8'h00, 0,3'd0, 0,3'd0);
        cyc(0, 1,3'd5,8'h55,0,8'h00, 0,3'd0, 0,3'd0);
        cyc(1, 1,3'd7,8'h77,0,8'h00, 0,3'd0, 0,3'd0);
        cyc(0, 0,3'd0,8'h00,0,8'h00, 1,3'd5, 1,3'd7);
        exp_push(DA, F_WR,    8'h00, "mid_rst_rf_write");
        exp_push(DA, F_DST,   8'h00, "mid_rst_destreg");
        exp_push(DA, F_WDAT,  8'h00, "mid_rst_wrtData");
        exp_push(DA, F_STALL, 8'h00, "mid_rst_stall_a");
        exp_push(DB, F_STALL, 8'h00, "mid_rst_stall_b");
        exp_push(DA, F_OP1,   8'hA5, "mid_rst_opnd1");
        exp_push(DA, F_OP2,   8'h99, "mid_rst_opnd2");
        cyc(0, 0,3'd0,8'h00,0,8'h00, 1,3'd5, 1,3'd7);
        exp_push(DA, F_WR,    8'h00, "mid_rst_rf_write2");
        exp_push(DA, F_OP1,   8'hA5, "mid_rst_r5_kept");
        exp_push(DA, F_OP2,   8'h99, "mid_rst_r7_kept");
        exp_push(DB, F_OP1,   8'hA5, "mid_rst_r5_kept_b");

        @(posedge clk);
        @(negedge clk);
        #1;
        check_rf(DA, 5, 8'hA5, "mid_rst_rf_a_r5");
        check_rf(DB, 5, 8'hA5, "mid_rst_rf_b_r5");
        check_rf(DA, 7, 8'h99, "mid_rst_rf_a_r7");
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL expectations_drained: %0d left", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
